iir_allpole_filter: RTL and testbench

//  Recursive (all-pole) 3-tap filter: y[n] = x[n] - a1*y[n-1] - a2*y[n-2] - a3*y[n-3].

---
 rtl/iir_pkg.sv | 29 ++
 rtl/iir_history.sv | 39 +++
 rtl/iir_allpole_filter.sv | 123 ++++++++++++
 tb/tb_iir_allpole_filter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// Shared types, constants and the output saturation helper for the all-pole IIR filter.
package iir_pkg;

  localparam int DATA_W  = 16;
  localparam int COEFF_W = 16;
  localparam int FRAC_W  = 15;
  localparam int ACC_W   = 36;
  localparam int PROD_W  = DATA_W + COEFF_W;

  typedef logic signed [DATA_W-1:0]  sample_t;
  typedef logic signed [COEFF_W-1:0] coeff_t;
  typedef logic signed [ACC_W-1:0]   acc_t;

  typedef enum logic [2:0] {IDLE, MAC1, MAC2, MAC3, DONE} state_t;

  // Half an output LSB, added once at accept so the final shift rounds half-up.
  localparam acc_t ROUND_BIAS = acc_t'(2 ** (FRAC_W - 1));
  localparam acc_t SAMPLE_MAX = acc_t'(2 ** (DATA_W - 1) - 1);
  localparam acc_t SAMPLE_MIN = -acc_t'(2 ** (DATA_W - 1));

  function automatic sample_t sat_to_sample(acc_t acc);
    acc_t shifted;
    shifted = acc >>> FRAC_W;
    if (shifted > SAMPLE_MAX)      return sample_t'(SAMPLE_MAX);
    else if (shifted < SAMPLE_MIN) return sample_t'(SAMPLE_MIN);
    else                           return sample_t'(shifted);
  endfunction

endpackage

// File: rtl/iir_history.sv
// Three-deep output history y[n-1..n-3] with synchronous clear and shift-enable.
module iir_history
  import iir_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    clear_i,
  input  logic    shift_i,
  input  sample_t y_i,
  output sample_t y1_o,
  output sample_t y2_o,
  output sample_t y3_o
);

  sample_t y1_q, y2_q, y3_q;

  // NOTE: sequential state uses non-blocking assignments so the three taps shift
  // together on one edge instead of collapsing into y1 within a single pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y1_q <= '0;
      y2_q <= '0;
      y3_q <= '0;
    end else if (clear_i) begin
      y1_q <= '0;
      y2_q <= '0;
      y3_q <= '0;
    end else if (shift_i) begin
      y1_q <= y_i;
      y2_q <= y1_q;
      y3_q <= y2_q;
    end
  end

  assign y1_o = y1_q;
  assign y2_o = y2_q;
  assign y3_o = y3_q;

endmodule

// File: rtl/iir_allpole_filter.sv
// All-pole 3-tap IIR: y[n] = x[n] - a1*y[n-1] - a2*y[n-2] - a3*y[n-3], one shared multiplier.
module iir_allpole_filter #(
  parameter int DATA_W  = 16,
  parameter int COEFF_W = 16,
  parameter int FRAC_W  = 15,
  parameter int ACC_W   = 36
) (
  input  logic                      i_clk,
  input  logic                      i_rstb,
  input  logic                      i_clear,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic signed [DATA_W-1:0]  i_data,
  input  logic signed [COEFF_W-1:0] i_coeff1,
  input  logic signed [COEFF_W-1:0] i_coeff2,
  input  logic signed [COEFF_W-1:0] i_coeff3,
  output logic                      o_valid,
  output logic signed [DATA_W-1:0]  o_data
);

  import iir_pkg::*;

  state_t                     state_q, state_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [COEFF_W-1:0]  a1_q, a1_d, a2_q, a2_d, a3_q, a3_d;
  logic signed [DATA_W-1:0]   o_data_q, o_data_d;
  logic                       o_valid_q, o_valid_d;

  sample_t                    y1, y2, y3, y_sat;
  logic                       hist_shift;
  logic signed [COEFF_W-1:0]  mul_coeff;
  logic signed [DATA_W-1:0]   mul_hist;
  logic signed [DATA_W+COEFF_W-1:0] product;

  iir_history u_history (
    .clk     (i_clk),
    .rst_n   (i_rstb),
    .clear_i (i_clear),
    .shift_i (hist_shift),
    .y_i     (y_sat),
    .y1_o    (y1),
    .y2_o    (y2),
    .y3_o    (y3)
  );

  // Shared multiplier: each MAC state pairs its latched coefficient with its history tap.
  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    mul_coeff = '0;
    mul_hist  = '0;
    case (state_q)
      MAC1:    begin mul_coeff = a1_q; mul_hist = y1; end
      MAC2:    begin mul_coeff = a2_q; mul_hist = y2; end
      MAC3:    begin mul_coeff = a3_q; mul_hist = y3; end
      default: begin mul_coeff = '0;   mul_hist = '0; end
    endcase
  end

  assign product = (DATA_W + COEFF_W)'(mul_coeff) * (DATA_W + COEFF_W)'(mul_hist);
  assign y_sat   = sat_to_sample(acc_q);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    a1_d       = a1_q;
    a2_d       = a2_q;
    a3_d       = a3_q;
    o_data_d   = o_data_q;
    o_valid_d  = 1'b0;
    hist_shift = 1'b0;
    if (i_clear) begin
      // Clear wins over an accept and aborts any sample in flight.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            acc_d   = (ACC_W'(i_data) <<< FRAC_W) + ROUND_BIAS;
            a1_d    = i_coeff1;
            a2_d    = i_coeff2;
            a3_d    = i_coeff3;
            state_d = MAC1;
          end
        end
        MAC1: begin acc_d = acc_q - ACC_W'(product); state_d = MAC2; end
        MAC2: begin acc_d = acc_q - ACC_W'(product); state_d = MAC3; end
        MAC3: begin acc_d = acc_q - ACC_W'(product); state_d = DONE; end
        DONE: begin
          o_data_d   = y_sat;
          o_valid_d  = 1'b1;
          hist_shift = 1'b1;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      a1_q      <= '0;
      a2_q      <= '0;
      a3_q      <= '0;
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      a1_q      <= a1_d;
      a2_q      <= a2_d;
      a3_q      <= a3_d;
      o_data_q  <= o_data_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;

endmodule

// File: tb/tb_iir_allpole_filter.sv
// Directed-vector bench for iir_allpole_filter with hand-computed expected outputs.
module tb_iir_allpole_filter;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               clear;
  logic               in_valid;
  logic               out_ready;
  logic signed [15:0] in_data;
  logic signed [15:0] c1, c2, c3;
  logic               out_valid;
  logic signed [15:0] out_data;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  iir_allpole_filter dut (
    .i_clk    (clk),
    .i_rstb   (rst_n),
    .i_clear  (clear),
    .i_valid  (in_valid),
    .o_ready  (out_ready),
    .i_data   (in_data),
    .i_coeff1 (c1),
    .i_coeff2 (c2),
    .i_coeff3 (c3),
    .o_valid  (out_valid),
    .o_data   (out_data)
  );

  // Drives one sample from IDLE and waits (bounded) for its o_valid pulse; lat = -1 on timeout.
  task automatic run_sample(input logic signed [15:0] x, output logic signed [15:0] y,
                            output int lat);
    y   = '0;
    lat = -1;
    in_data  = x;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        y   = out_data;
        lat = c;
        break;
      end
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    chk_cnt++;
    if (out_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", out_ready);
    else pass_cnt++;
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid);
    else pass_cnt++;
    chk_cnt++;
    if (out_data !== 16'sd0) $display("FAIL reset_data: got %0d expected 0", out_data);
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_passthrough();
    logic signed [15:0] y;
    int lat;
    c1 = 16'sd0; c2 = 16'sd0; c3 = 16'sd0;
    run_sample(-16'sd12345, y, lat);
    chk_cnt++;
    if (y !== -16'sd12345) $display("FAIL pass_neg: got %0d expected -12345", y);
    else pass_cnt++;
    chk_cnt++;
    if (lat !== 4) $display("FAIL pass_latency: got %0d expected 4", lat);
    else pass_cnt++;
    run_sample(16'sd32767, y, lat);
    chk_cnt++;
    if (y !== 16'sd32767) $display("FAIL pass_max: got %0d expected 32767", y);
    else pass_cnt++;
  endtask

  task automatic test_decay();
    logic signed [15:0] xs [4] = '{16'sd16384, 16'sd0, 16'sd0, 16'sd0};
    logic signed [15:0] ys [4] = '{16'sd16384, 16'sd8192, 16'sd4096, 16'sd2048};
    logic signed [15:0] y;
    int lat;
    pulse_clear();
    c1 = 16'shC000; c2 = 16'sd0; c3 = 16'sd0;
    for (int i = 0; i < 4; i++) begin
      run_sample(xs[i], y, lat);
      chk_cnt++;
      if (y !== ys[i]) $display("FAIL decay_%0d: got %0d expected %0d", i, y, ys[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_saturation();
    logic signed [15:0] y;
    int lat;
    pulse_clear();
    c1 = 16'sh8000; c2 = 16'sd0; c3 = 16'sd0;
    run_sample(16'sd30000, y, lat);
    chk_cnt++;
    if (y !== 16'sd30000) $display("FAIL sat_pos_first: got %0d expected 30000", y);
    else pass_cnt++;
    run_sample(16'sd30000, y, lat);
    chk_cnt++;
    if (y !== 16'sd32767) $display("FAIL sat_pos: got %0d expected 32767", y);
    else pass_cnt++;
    pulse_clear();
    run_sample(-16'sd30000, y, lat);
    chk_cnt++;
    if (y !== -16'sd30000) $display("FAIL sat_neg_first: got %0d expected -30000", y);
    else pass_cnt++;
    run_sample(-16'sd30000, y, lat);
    chk_cnt++;
    if (y !== -16'sd32768) $display("FAIL sat_neg: got %0d expected -32768", y);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic signed [15:0] samples [5] = '{16'sd1000, -16'sd2000, 16'sd3000, -16'sd4000, 16'sd5000};
    logic signed [15:0] outs [8];
    int acc_cyc [8];
    int out_cyc [8];
    int n_acc = 0;
    int n_out = 0;
    logic will_accept;
    pulse_clear();
    c1 = 16'sd0; c2 = 16'sd0; c3 = 16'sd0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      in_valid = (cyc < 20);
      in_data  = samples[n_acc];
      will_accept = in_valid && out_ready;
      @(posedge clk); #1;
      if (will_accept && n_acc < 4) begin acc_cyc[n_acc] = cyc; n_acc++; end
      else if (will_accept) n_acc++;
      if (out_valid && n_out < 8) begin outs[n_out] = out_data; out_cyc[n_out] = cyc; n_out++; end
    end
    in_valid = 1'b0;
    chk_cnt++;
    if (n_acc !== 4) $display("FAIL b2b_accepts: got %0d expected 4", n_acc);
    else pass_cnt++;
    chk_cnt++;
    if (n_out !== 4) $display("FAIL b2b_outputs: got %0d expected 4", n_out);
    else pass_cnt++;
    for (int i = 0; i < 4 && i < n_out; i++) begin
      chk_cnt++;
      if (outs[i] !== samples[i]) $display("FAIL b2b_data_%0d: got %0d expected %0d", i, outs[i], samples[i]);
      else pass_cnt++;
    end
    for (int i = 1; i < 4 && i < n_acc && i < n_out; i++) begin
      chk_cnt++;
      if (acc_cyc[i] - acc_cyc[i-1] !== 5)
        $display("FAIL b2b_accept_gap_%0d: got %0d expected 5", i, acc_cyc[i] - acc_cyc[i-1]);
      else pass_cnt++;
      chk_cnt++;
      if (out_cyc[i] - out_cyc[i-1] !== 5)
        $display("FAIL b2b_output_gap_%0d: got %0d expected 5", i, out_cyc[i] - out_cyc[i-1]);
      else pass_cnt++;
    end
  endtask

  task automatic test_clear();
    logic signed [15:0] y;
    int lat;
    int seen_valid = 0;
    int not_ready  = 0;
    test_decay();
    in_data  = 16'sd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen_valid++;
      @(posedge clk); #1;
    end
    chk_cnt++;
    if (seen_valid !== 0) $display("FAIL clear_abort_valid: got %0d pulses expected 0", seen_valid);
    else pass_cnt++;
    c1 = 16'shC000;
    run_sample(16'sd100, y, lat);
    chk_cnt++;
    if (y !== 16'sd100) $display("FAIL clear_history: got %0d expected 100", y);
    else pass_cnt++;
    in_data  = 16'sd50;
    in_valid = 1'b1;
    clear    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    clear    = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen_valid++;
      if (!out_ready) not_ready++;
      @(posedge clk); #1;
    end
    chk_cnt++;
    if (not_ready !== 0) $display("FAIL clear_accept_ready: got %0d busy cycles expected 0", not_ready);
    else pass_cnt++;
    chk_cnt++;
    if (seen_valid !== 0) $display("FAIL clear_accept_valid: got %0d pulses expected 0", seen_valid);
    else pass_cnt++;
    chk_cnt++;
    if (out_data !== 16'sd100) $display("FAIL clear_hold_data: got %0d expected 100", out_data);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic signed [15:0] y;
    int lat;
    in_data  = 16'sd9;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL midrst_valid: got %b expected 0", out_valid);
    else pass_cnt++;
    chk_cnt++;
    if (out_data !== 16'sd0) $display("FAIL midrst_data: got %0d expected 0", out_data);
    else pass_cnt++;
    chk_cnt++;
    if (out_ready !== 1'b1) $display("FAIL midrst_ready: got %b expected 1", out_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_sample(16'sd5, y, lat);
    chk_cnt++;
    if (y !== 16'sd5) $display("FAIL midrst_after: got %0d expected 5", y);
    else pass_cnt++;
    chk_cnt++;
    if (lat !== 4) $display("FAIL midrst_latency: got %0d expected 4", lat);
    else pass_cnt++;
  endtask

  initial begin
    rst_n    = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    c1 = '0; c2 = '0; c3 = '0;
    #2;
    test_reset();
    test_passthrough();
    test_decay();
    test_saturation();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
